// File: rtl/case_mux_reg.sv
// Registered N-to-1 channel selector with valid/ready on both sides, fixed or round-robin select.
// Optional CASE_MUX_ERR_CNT_EN adds a saturating invalid-select counter on err_cnt_o.
module case_mux_reg #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   din_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [SELW-1:0]        sel_i,
  input  logic                   mode_i,
  input  logic                   err_clr_i,
  output logic [WIDTH-1:0]       y_o,
  output logic                   y_valid_o,
  input  logic                   y_ready_i,
  output logic [SELW-1:0]        cur_ch_o,
  output logic                   sel_err_o
`ifdef CASE_MUX_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt_o
`endif
);

  localparam int unsigned SELX = SELW + 1;
  localparam int unsigned CNTW = 8;

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SELW-1:0]  cur_ch_q, cur_ch_d;
  logic             sel_err_q, sel_err_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic             sel_ok;
  logic             bad_acc;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  pick_idx;
  logic [WIDTH-1:0] pick_data;

  // Only the handshake path is combinational from input to output.
  assign in_ready_o = !y_valid_q || y_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign sel_ok   = ({1'b0, sel_i} < SELX'(NCH));
  assign bad_acc  = accept && !mode_i && !sel_ok;
  // A fresh entry into round-robin mode restarts the scan at channel 0.
  assign rr_idx   = mode_q ? ptr_q : '0;
  assign pick_idx = mode_i ? rr_idx : sel_i;

  // Explicit compare-per-channel mux keeps out-of-range selects from indexing din_i.
  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (pick_idx == SELW'(k)) begin
        pick_data = din_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output register, scan pointer and error flag.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    cur_ch_d  = cur_ch_q;
    sel_err_d = sel_err_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;

    if (accept) begin
      mode_d = mode_i;
      if (mode_i) begin
        y_d       = pick_data;
        cur_ch_d  = rr_idx;
        y_valid_d = 1'b1;
        ptr_d     = (rr_idx == SELW'(NCH - 1)) ? '0 : rr_idx + SELW'(1);
      end else if (sel_ok) begin
        y_d       = pick_data;
        cur_ch_d  = sel_i;
        y_valid_d = 1'b1;
      end else if (y_ready_i) begin
        y_valid_d = 1'b0;
      end
    end else if (y_ready_i && y_valid_q) begin
      y_valid_d = 1'b0;
    end

    // A concurrent invalid select takes priority over the clear.
    if (bad_acc) begin
      sel_err_d = 1'b1;
    end else if (err_clr_i) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cur_ch_q  <= '0;
      sel_err_q <= 1'b0;
      ptr_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cur_ch_q  <= cur_ch_d;
      sel_err_q <= sel_err_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign cur_ch_o  = cur_ch_q;
  assign sel_err_o = sel_err_q;

`ifdef CASE_MUX_ERR_CNT_EN
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted invalid selects; clear plus new error yields 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = bad_acc ? CNTW'(1) : '0;
    end else if (bad_acc && (err_cnt_q != {CNTW{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_case_mux_reg.sv
// Directed bench for case_mux_reg: a 4-channel instance with a reference model and result
// scoreboard, plus a 3-channel instance for invalid selects (and err_cnt when compiled in).
module tb_case_mux_reg;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [4*W-1:0] din;
  logic           in_valid, in_ready, mode, err_clr, y_ready, y_valid, sel_err;
  logic [1:0]     sel, cur_ch;
  logic [W-1:0]   y;
  // 3-channel instance
  logic [3*W-1:0] din3;
  logic           v3, ir3, mode3, clr3, yr3, yv3, err3;
  logic [1:0]     sel3, ch3;
  logic [W-1:0]   y3;
`ifdef CASE_MUX_ERR_CNT_EN
  logic [7:0]     cnt, cnt3;
`endif

  case_mux_reg #(.NCH(4), .WIDTH(W), .SELW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_i(din), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sel_i(sel), .mode_i(mode), .err_clr_i(err_clr), .y_o(y), .y_valid_o(y_valid),
    .y_ready_i(y_ready), .cur_ch_o(cur_ch), .sel_err_o(sel_err)
`ifdef CASE_MUX_ERR_CNT_EN
    , .err_cnt_o(cnt)
`endif
  );

  case_mux_reg #(.NCH(3), .WIDTH(W), .SELW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din_i(din3), .in_valid_i(v3), .in_ready_o(ir3),
    .sel_i(sel3), .mode_i(mode3), .err_clr_i(clr3), .y_o(y3), .y_valid_o(yv3),
    .y_ready_i(yr3), .cur_ch_o(ch3), .sel_err_o(err3)
`ifdef CASE_MUX_ERR_CNT_EN
    , .err_cnt_o(cnt3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state of the 4-channel instance
  logic         m_yv, m_modeq;
  logic [W-1:0] m_y;
  logic [1:0]   m_ch;
  int           m_ptr;
  logic [W+1:0] sbq[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_yv = 1'b0; m_modeq = 1'b0; m_y = '0; m_ch = '0; m_ptr = 0;
    sbq.delete();
  endtask

  // One clock on the 4-channel instance with inputs already driven; called just after a negedge.
  task automatic step();
    logic         acc;
    int           ch;
    logic [W+1:0] ent;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_yv || y_ready));
    acc = in_valid && (!m_yv || y_ready);
    if (acc) begin
      ch = mode ? (m_modeq ? m_ptr : 0) : int'(sel);
      sbq.push_back({din[ch*W +: W], 2'(ch)});
      if (mode) m_ptr = (ch == 3) ? 0 : ch + 1;
      m_modeq = mode;
      m_yv = 1'b1;
    end else if (y_ready) begin
      m_yv = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("y_valid", 32'(y_valid), 32'(m_yv));
    if (acc) begin
      if (sbq.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        ent  = sbq.pop_front();
        m_y  = ent[W+1:2];
        m_ch = ent[1:0];
      end
    end
    check("y", 32'(y), 32'(m_y));
    check("cur_ch", 32'(cur_ch), 32'(m_ch));
  endtask

  initial begin
    rst_n = 1'b0;
    din = 32'h44332211; in_valid = 1'b0; sel = 2'd0; mode = 1'b0; err_clr = 1'b0; y_ready = 1'b1;
    din3 = 24'hCCBBAA; v3 = 1'b0; sel3 = 2'd0; mode3 = 1'b0; clr3 = 1'b0; yr3 = 1'b1;
    model_reset();
    #12;
    check("rst_y", 32'(y), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_cur_ch", 32'(cur_ch), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed select: channel 2 then channel 0
    in_valid = 1'b1; sel = 2'd2; step();
    check("fix_y_ch2", 32'(y), 32'h33);
    sel = 2'd0; step();
    check("fix_y_ch0", 32'(y), 32'h11);
    in_valid = 1'b0; step();

    // Round-robin scan over six back-to-back transfers
    mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = $urandom();
      step();
      check("rr_seq", 32'(cur_ch), i % 4);
    end
    mode = 1'b0; sel = 2'd3; step();
    mode = 1'b1; step();
    check("rr_restart", 32'(cur_ch), 0);
    step();
    check("rr_next", 32'(cur_ch), 1);

    // Backpressure: capture once, then stall five cycles, then release
    in_valid = 1'b0; step();
    y_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 2'd3; din = 32'hA4A3A2A1; step();
    check("bp_capture", 32'(y), 32'hA4);
    sel = 2'd1; din = 32'h5A5B5C5D;
    for (int i = 0; i < 5; i++) step();
    check("bp_hold_y", 32'(y), 32'hA4);
    y_ready = 1'b1; step();
    check("bp_release", 32'(y), 32'h5C);
    in_valid = 1'b0; step();

    // Invalid select on the 3-channel instance
    v3 = 1'b1; sel3 = 2'd1; step();
    check("nch3_valid_y", 32'(y3), 32'hBB);
    check("nch3_valid_yv", 32'(yv3), 1);
    sel3 = 2'd3; step();
    check("inv_sel_err", 32'(err3), 1);
    check("inv_y_valid", 32'(yv3), 0);
    check("inv_y_hold", 32'(y3), 32'hBB);
    check("inv_ch_hold", 32'(ch3), 1);
    clr3 = 1'b1; step();
    check("clr_vs_inv", 32'(err3), 1);
`ifdef CASE_MUX_ERR_CNT_EN
    check("cnt_clr_inv", 32'(cnt3), 1);
`endif
    v3 = 1'b0; step();
    check("clr_alone", 32'(err3), 0);
`ifdef CASE_MUX_ERR_CNT_EN
    check("cnt_clr_alone", 32'(cnt3), 0);
    clr3 = 1'b0; v3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 260; i++) step();
    check("cnt_saturate", 32'(cnt3), 255);
    clr3 = 1'b1; step();
    check("cnt_clr_plus_inv", 32'(cnt3), 1);
    check("cnt_main_zero", 32'(cnt), 0);
`endif
    clr3 = 1'b0; v3 = 1'b1; sel3 = 2'd3; step();
    v3 = 1'b0;

    // Asynchronous reset while y=0x22 is held
    y_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 2'd1; din = 32'h44332211; step();
    check("pre_rst_y", 32'(y), 32'h22);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", 32'(y), 0);
    check("arst_y_valid", 32'(y_valid), 0);
    check("arst_cur_ch", 32'(cur_ch), 0);
    check("arst_sel_err3", 32'(err3), 0);
    check("arst_in_ready", 32'(in_ready), 1);
`ifdef CASE_MUX_ERR_CNT_EN
    check("arst_cnt3", 32'(cnt3), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    y_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; din = 32'hD4D3D2D1; step();
    check("post_rst_rr0", 32'(cur_ch), 0);
    step();
    check("post_rst_rr1", 32'(cur_ch), 1);
    in_valid = 1'b0; step();
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
